// File: rtl/cmsdk_apb4_eg_slave_reg_gen.sv
//------------------------------------------------------------------------------
// cmsdk_apb4_eg_slave_reg_gen
//
// Parametrised register block for the APB4 example slave. It provides
// NUM_REGS byte-strobed 32-bit data registers, the fixed PID/CID
// identification space at 0xFD0-0xFFC, a programmable wait-state handshake
// (ready) and an error response (slverr). The APB4 wrapper drives
// req = psel & penable and forwards ready/slverr to pready/pslverr.
//
// Optional feature:
//   CMSDK_APB4_EG_SLAVE_REG_LOCK_EN - when defined, adds a lock register at
//   offset 0xF00. Writing 32'h1ACCE551 with all four strobes unlocks; any
//   other write locks. While locked, data register writes are dropped and
//   answered with slverr. When undefined, 0xF00 is an ordinary unmapped
//   address.
//
// Parameters:
//   ADDRWIDTH   - byte address width (12..16)
//   NUM_REGS    - number of data registers (1..64), register k at 4*k
//   WAIT_STATES - extra wait cycles per access (0..15)
//   RESET_VAL   - reset value of every data register
//
// Ports:
//   pclk        in   clock
//   presetn     in   asynchronous active-low reset
//   req         in   access request, held high until ready
//   write       in   1 = write, 0 = read, stable while req is high
//   addr        in   byte address (bits [1:0] ignored)
//   byte_strobe in   write byte enables (ignored on reads)
//   wdata       in   write data
//   ecorevnum   in   ECO revision number, returned in PID3[7:4]
//   rdata       out  read data, valid only while ready is high
//   ready       out  one-cycle transfer-complete pulse
//   slverr      out  error flag, valid only while ready is high
//------------------------------------------------------------------------------
module cmsdk_apb4_eg_slave_reg_gen #(
    parameter int          ADDRWIDTH   = 12,
    parameter int          NUM_REGS    = 4,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 req,
    input  logic                 write,
    input  logic [ADDRWIDTH-1:0] addr,
    input  logic [3:0]           byte_strobe,
    input  logic [31:0]          wdata,
    input  logic [3:0]           ecorevnum,
    output logic [31:0]          rdata,
    output logic                 ready,
    output logic                 slverr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] UNLOCK_KEY = 32'h1ACC_E551;

    state_t      state;
    logic [3:0]  cnt;

    logic [31:0] regs [NUM_REGS];

    // Request captured in IDLE
    logic                 write_p0;
    logic [ADDRWIDTH-1:0] addr_p0;
    logic [3:0]           strobe_p0;
    logic [31:0]          wdata_p0;

    // Effective access attributes
    logic                 acc_write;
    logic [ADDRWIDTH-1:0] acc_addr;
    logic [3:0]           acc_strobe;
    logic [31:0]          acc_wdata;

    logic [15:0] addr_ext;
    logic [13:0] word_idx;
    logic        hi_zero;
    logic        data_hit;
    logic        id_hit;
    logic        lock_hit;
    logic        locked;
    logic        go_resp;
    logic        err;
    logic        commit;
    logic        data_we;
    logic [31:0] rd_val;
    logic        unused_addr_lsbs;

    // Merge new bytes into an old word under a byte-enable mask.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    // PID/CID table, indexed by word address bits [11:2].
    function automatic logic [31:0] id_value(input logic [9:0] widx,
                                             input logic [3:0] eco);
        logic [31:0] v;
        case (widx)
            10'h3F4: v = 32'h0000_0004;            // PID4
            10'h3F8: v = 32'h0000_0019;            // PID0
            10'h3F9: v = 32'h0000_00B8;            // PID1
            10'h3FA: v = 32'h0000_001B;            // PID2
            10'h3FB: v = {24'h0, eco, 4'h0};       // PID3
            10'h3FC: v = 32'h0000_000D;            // CID0
            10'h3FD: v = 32'h0000_00F0;            // CID1
            10'h3FE: v = 32'h0000_0005;            // CID2
            10'h3FF: v = 32'h0000_00B1;            // CID3
            default: v = 32'h0000_0000;            // PID5-7 and holes
        endcase
        return v;
    endfunction

    // With zero wait states the commit edge is the same edge that samples
    // the request, so the live inputs are used in IDLE and the captured
    // copy afterwards.
    always_comb begin
        if (state == ST_IDLE) begin
            acc_write  = write;
            acc_addr   = addr;
            acc_strobe = byte_strobe;
            acc_wdata  = wdata;
        end else begin
            acc_write  = write_p0;
            acc_addr   = addr_p0;
            acc_strobe = strobe_p0;
            acc_wdata  = wdata_p0;
        end
    end

    // Address decode on a zero-extended 16-bit view of the address
    assign addr_ext         = 16'(acc_addr);
    assign word_idx         = addr_ext[15:2];
    assign hi_zero          = (addr_ext[15:12] == 4'h0);
    assign data_hit         = (word_idx < 14'(NUM_REGS));
    assign id_hit           = hi_zero && (addr_ext[11:4] >= 8'hFD);
    assign unused_addr_lsbs = ^addr_ext[1:0];

`ifdef CMSDK_APB4_EG_SLAVE_REG_LOCK_EN
    assign lock_hit = hi_zero && (addr_ext[11:2] == 10'h3C0);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            locked <= 1'b0;
        end else if (commit && lock_hit) begin
            locked <= !((acc_wdata == UNLOCK_KEY) && (acc_strobe == 4'hF));
        end
    end
`else
    assign lock_hit = 1'b0;
    assign locked   = 1'b0;
`endif

    // Transfer completes on this edge
    always_comb begin
        go_resp = 1'b0;
        case (state)
            ST_IDLE: go_resp = req && (WAIT_STATES == 0);
            ST_WAIT: go_resp = req && (cnt == 4'(WAIT_STATES));
            default: go_resp = 1'b0;
        endcase
    end

    // Errors: writes outside any writable location, to the ID space, or to
    // a data register while locked. An all-zero strobe is a silent no-op.
    assign err     = acc_write &&
                     (id_hit || (data_hit && locked) || !(data_hit || lock_hit));
    assign commit  = go_resp && acc_write && !err;
    assign data_we = commit && data_hit;

    always_comb begin
        rd_val = 32'h0;
        if (!acc_write) begin
            if (data_hit) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (word_idx == 14'(k)) begin
                        rd_val = regs[k];
                    end
                end
            end else if (lock_hit) begin
                rd_val = {31'b0, locked};
            end else if (id_hit) begin
                rd_val = id_value(addr_ext[11:2], ecorevnum);
            end
        end
    end

    // ---- Stage p0: capture request attributes in IDLE ----
    always_ff @(posedge pclk) begin
        if ((state == ST_IDLE) && req) begin
            write_p0  <= write;
            addr_p0   <= addr;
            strobe_p0 <= byte_strobe;
            wdata_p0  <= wdata;
        end
    end

    // ---- Control FSM with registered outputs ----
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            ready  <= 1'b0;
            slverr <= 1'b0;
            rdata  <= 32'h0;
        end else begin
            ready  <= go_resp;
            slverr <= go_resp && err;
            rdata  <= go_resp ? rd_val : 32'h0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        if (WAIT_STATES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= 4'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!req) begin
                        // Aborted transfer: nothing is committed
                        state <= ST_IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'(WAIT_STATES)) begin
                        state <= ST_RESP;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    // ---- Data registers ----
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= RESET_VAL;
            end
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (data_we && (word_idx == 14'(k))) begin
                    regs[k] <= merge_bytes(regs[k], acc_wdata, acc_strobe);
                end
            end
        end
    end

endmodule
